// File: rtl/addsub_pkg.sv
// rtl/addsub_pkg.sv - mode encoding and add/subtract select constants for addsub_acc_pipe
package addsub_pkg;

    localparam logic [1:0] MODE_DUAL    = 2'b00;
    localparam logic [1:0] MODE_ACC     = 2'b01;
    localparam logic [1:0] MODE_LOAD    = 2'b10;
    localparam logic [1:0] MODE_RESTART = 2'b11;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/addsub_delay_line.sv
// rtl/addsub_delay_line.sv - valid-qualified delay line; data advances only with its valid bit
module addsub_delay_line #(
    parameter int WIDTH = 50,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    if (DEPTH == 0) begin : g_pass
        assign out_valid = in_valid;
        assign out_data  = in_data;
    end else begin : g_regs
        logic [DEPTH-1:0]            valid_q;
        logic [DEPTH-1:0][WIDTH-1:0] data_q;

        // Valid shifts every cycle; data moves only behind a valid bit so the tail holds the last result
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                valid_q <= '0;
                data_q  <= '0;
            end else begin
                valid_q[0] <= in_valid;
                if (in_valid) begin
                    data_q[0] <= in_data;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    valid_q[i] <= valid_q[i-1];
                    if (valid_q[i-1]) begin
                        data_q[i] <= data_q[i-1];
                    end
                end
            end
        end

        assign out_valid = valid_q[DEPTH-1];
        assign out_data  = data_q[DEPTH-1];
    end

endmodule

// File: rtl/addsub_acc_pipe.sv
// rtl/addsub_acc_pipe.sv - pipelined add/subtract with accumulator; ADDSUB_SAT_EN enables saturation
module addsub_acc_pipe
    import addsub_pkg::*;
#(
    parameter int WIDTH       = 48,
    parameter int PIPE_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a_in,
    input  logic [WIDTH-1:0] c_in,
    input  logic             add_sub,
    input  logic [1:0]       mode,
    output logic             out_valid,
    output logic [WIDTH-1:0] addsub_out,
    output logic             carry_out,
    output logic             overflow
);

    localparam int MSB = WIDTH - 1;

`ifdef ADDSUB_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = {1'b1, {(WIDTH-1){1'b0}}};
`endif

    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] base;
    logic [WIDTH:0]   sum_ext;
    logic [WIDTH:0]   diff_ext;
    logic [WIDTH-1:0] raw;
    logic [WIDTH-1:0] result;
    logic             carry;
    logic             ovf;

    logic             s1_valid;
    logic [WIDTH+1:0] s1_data;
    logic [WIDTH+1:0] tail_data;

    // Pick the minuend/augend, form the result and its flags from current inputs and current ACC
    always_comb begin
        base   = c_in;
        raw    = '0;
        result = '0;
        carry  = 1'b0;
        ovf    = 1'b0;
        unique case (mode)
            MODE_ACC:     base = acc;
            MODE_RESTART: base = '0;
            default:      base = c_in;
        endcase
        sum_ext  = {1'b0, base} + {1'b0, a_in};
        diff_ext = {1'b0, base} - {1'b0, a_in};
        unique case (add_sub)
            OP_ADD: begin
                raw   = sum_ext[WIDTH-1:0];
                carry = sum_ext[WIDTH];
                ovf   = (base[MSB] == a_in[MSB]) && (raw[MSB] != base[MSB]);
            end
            OP_SUB: begin
                raw   = diff_ext[WIDTH-1:0];
                carry = diff_ext[WIDTH];
                ovf   = (base[MSB] != a_in[MSB]) && (raw[MSB] != base[MSB]);
            end
            default: begin
                raw = sum_ext[WIDTH-1:0];
            end
        endcase
        result = raw;
`ifdef ADDSUB_SAT_EN
        // On overflow the true result carries the sign of the base operand
        if (ovf) begin
            result = base[MSB] ? SAT_MIN : SAT_MAX;
        end
`endif
        if (mode == MODE_LOAD) begin
            result = c_in;
            carry  = 1'b0;
            ovf    = 1'b0;
        end
    end

    // Stage 1 capture and accumulator write share the accepting edge so ACC ops chain back-to-back
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc      <= '0;
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= {ovf, carry, result};
                if (mode != MODE_DUAL) begin
                    acc <= result;
                end
            end
        end
    end

    addsub_delay_line #(
        .WIDTH (WIDTH + 2),
        .DEPTH (PIPE_STAGES - 1)
    ) u_delay (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (s1_valid),
        .in_data   (s1_data),
        .out_valid (out_valid),
        .out_data  (tail_data)
    );

    assign addsub_out = tail_data[WIDTH-1:0];
    assign carry_out  = tail_data[WIDTH];
    assign overflow   = tail_data[WIDTH+1];

endmodule
